// File: rtl/seven_seg_pkg.sv
// Shared constants for the MM.SS seven-segment display driver.
// Holds the active-low gfedcba digit encodings, digit slot indices and the BCD split helper.
package seven_seg_pkg;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  localparam logic [1:0] DIG_SU = 2'd0;
  localparam logic [1:0] DIG_ST = 2'd1;
  localparam logic [1:0] DIG_MU = 2'd2;
  localparam logic [1:0] DIG_MT = 2'd3;

  // Values 60..63 give a tens digit of 6, so they show as "60".."63".
  function automatic logic [3:0] digit_of(input logic [5:0] v, input logic tens);
    return tens ? 4'(v / 6'd10) : 4'(v % 6'd10);
  endfunction

endpackage

// File: rtl/seven_seg_display_seg_decoder.sv
// Combinational BCD digit to active-low seven-segment decoder.
// Codes 10..15 are not digits and light nothing.
module seg_decoder
  import seven_seg_pkg::*;
(
  input  logic [3:0] digit,
  output logic [6:0] seg
);

  // NOTE: seg gets a default before the case so no path through this block infers a latch.
  always_comb begin
    seg = SEG_BLANK;
    case (digit)
      4'd0: seg = SEG_0;
      4'd1: seg = SEG_1;
      4'd2: seg = SEG_2;
      4'd3: seg = SEG_3;
      4'd4: seg = SEG_4;
      4'd5: seg = SEG_5;
      4'd6: seg = SEG_6;
      4'd7: seg = SEG_7;
      4'd8: seg = SEG_8;
      4'd9: seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/seven_seg_display.sv
// Time-multiplexed 4-digit MM.SS driver for a common-anode display.
// Snapshots the time once per frame and blinks the field under adjustment.
module seven_seg_display
  import seven_seg_pkg::*;
#(
  parameter int BASE_CLK   = 100_000_000,
  parameter int REFRESH_HZ = 500,
  parameter int BLINK_HZ   = 2
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [5:0] MINUTES,
  input  logic [5:0] SECONDS,
  input  logic       ADJ,
  input  logic       SEL,
  output logic [6:0] SEG,
  output logic       DP,
  output logic [3:0] AN
);

  localparam int REFRESH_DIV = BASE_CLK / REFRESH_HZ;
  localparam int BLINK_DIV   = BASE_CLK / (2 * BLINK_HZ);
  localparam int RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  logic [RW-1:0] refresh_cnt;
  logic [BW-1:0] blink_cnt, blink_cnt_n;
  logic          blink_phase, blink_phase_n;
  logic [1:0]    dig_idx;
  logic [5:0]    snap_min, snap_sec, disp_min, disp_sec;
  logic          load_pending, adj_q;
  logic          tick, load_now, adj_rise, blank;
  logic [3:0]    digit, an_n;
  logic [6:0]    seg_n;
  logic          dp_n;

  always_comb begin
    tick     = (refresh_cnt == RW'(REFRESH_DIV - 1));
    load_now = load_pending | (tick & (dig_idx == DIG_MT));
    adj_rise = ADJ & ~adj_q;

    blink_cnt_n   = blink_cnt + 1'b1;
    blink_phase_n = blink_phase;
    if (adj_rise) begin
      blink_cnt_n   = '0;
      blink_phase_n = 1'b0;
    end else if (blink_cnt == BW'(BLINK_DIV - 1)) begin
      blink_cnt_n   = '0;
      blink_phase_n = ~blink_phase;
    end

    // Right after reset the snapshot is still empty, so show the inputs it is about to capture.
    disp_min = load_pending ? MINUTES : snap_min;
    disp_sec = load_pending ? SECONDS : snap_sec;

    digit = '0;
    case (dig_idx)
      DIG_SU: digit = digit_of(disp_sec, 1'b0);
      DIG_ST: digit = digit_of(disp_sec, 1'b1);
      DIG_MU: digit = digit_of(disp_min, 1'b0);
      DIG_MT: digit = digit_of(disp_min, 1'b1);
      default: digit = '0;
    endcase

    // Blanking follows the upcoming phase so the half-period after an ADJ edge is fully visible.
    blank = ADJ & blink_phase_n & (dig_idx[1] == ~SEL);
    an_n  = blank ? 4'b1111 : ~(4'b0001 << dig_idx);
    dp_n  = ~((dig_idx == DIG_MU) & ~blank);
  end

  seg_decoder u_seg_decoder (
    .digit (digit),
    .seg   (seg_n)
  );

  // NOTE: all state here uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      refresh_cnt  <= '0;
      dig_idx      <= DIG_SU;
      blink_cnt    <= '0;
      blink_phase  <= 1'b0;
      adj_q        <= 1'b0;
      snap_min     <= '0;
      snap_sec     <= '0;
      load_pending <= 1'b1;
      AN           <= 4'b1111;
      SEG          <= SEG_BLANK;
      DP           <= 1'b1;
    end else begin
      refresh_cnt  <= tick ? '0 : refresh_cnt + 1'b1;
      if (tick) dig_idx <= dig_idx + 1'b1;
      blink_cnt    <= blink_cnt_n;
      blink_phase  <= blink_phase_n;
      adj_q        <= ADJ;
      if (load_now) begin
        snap_min <= MINUTES;
        snap_sec <= SECONDS;
      end
      load_pending <= 1'b0;
      AN           <= an_n;
      SEG          <= seg_n;
      DP           <= dp_n;
    end
  end

endmodule

// File: tb/tb_seven_seg_display.sv
// Directed bench for seven_seg_display: scan order, frame snapshot, blinking, boundary values, async reset.
// Scaled clocks: a digit advance every 4 cycles, blink phase every 8 cycles.
module tb_seven_seg_display;

  localparam logic [6:0] S0 = 7'b1000000;
  localparam logic [6:0] S1 = 7'b1111001;
  localparam logic [6:0] S2 = 7'b0100100;
  localparam logic [6:0] S3 = 7'b0110000;
  localparam logic [6:0] S4 = 7'b0011001;
  localparam logic [6:0] S5 = 7'b0010010;
  localparam logic [6:0] S6 = 7'b0000010;
  localparam logic [6:0] S7 = 7'b1111000;
  localparam logic [6:0] S9 = 7'b0010000;
  localparam logic [6:0] SB = 7'b1111111;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [5:0] minutes, seconds;
  logic       adj, sel;
  logic [6:0] seg;
  logic       dp;
  logic [3:0] an;

  int vectors     = 0;
  int miscompares = 0;

  seven_seg_display #(
    .BASE_CLK   (16),
    .REFRESH_HZ (4),
    .BLINK_HZ   (1)
  ) dut (
    .i_clk   (clk),
    .i_rst   (rst),
    .MINUTES (minutes),
    .SECONDS (seconds),
    .ADJ     (adj),
    .SEL     (sel),
    .SEG     (seg),
    .DP      (dp),
    .AN      (an)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [3:0] an_e, input logic [6:0] seg_e,
                       input logic dp_e, input bit chk_seg);
    vectors++;
    assert (an === an_e && dp === dp_e && (!chk_seg || seg === seg_e)) else begin
      miscompares++;
      $error("FAIL %s: got AN=%b SEG=%b DP=%b, expected AN=%b SEG=%b DP=%b",
             tag, an, seg, dp, an_e, seg_e, dp_e);
    end
  endtask

  // n clock cycles, each sampled at the falling edge against one expected digit.
  task automatic run(input string tag, input int n, input logic [3:0] an_e,
                     input logic [6:0] seg_e, input logic dp_e);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check(tag, an_e, seg_e, dp_e, 1'b1);
    end
  endtask

  task automatic run_blank(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check(tag, 4'b1111, SB, 1'b1, 1'b0);
    end
  endtask

  initial begin
    minutes = 6'd12; seconds = 6'd34; adj = 1'b0; sel = 1'b0; rst = 1'b1;
    repeat (2) @(negedge clk);
    check("reset_hold", 4'b1111, SB, 1'b1, 1'b1);
    rst = 1'b0;

    run("f1_su", 4, 4'b1110, S4, 1'b1);
    run("f1_st", 4, 4'b1101, S3, 1'b1);
    run("f1_mu", 4, 4'b1011, S2, 1'b0);
    run("f1_mt", 4, 4'b0111, S1, 1'b1);

    run("f2_su", 4, 4'b1110, S4, 1'b1);
    run("f2_st", 1, 4'b1101, S3, 1'b1);
    seconds = 6'd59;
    run("f2_st_held", 3, 4'b1101, S3, 1'b1);
    run("f2_mu_held", 4, 4'b1011, S2, 1'b0);
    run("f2_mt_held", 4, 4'b0111, S1, 1'b1);

    run("f3_su", 4, 4'b1110, S9, 1'b1);
    run("f3_st", 4, 4'b1101, S5, 1'b1);
    run("f3_mu", 4, 4'b1011, S2, 1'b0);
    run("f3_mt", 4, 4'b0111, S1, 1'b1);

    // Seconds blink, ADJ raised two cycles into the seconds-tens slot.
    run("f4_su", 4, 4'b1110, S9, 1'b1);
    run("f4_st", 2, 4'b1101, S5, 1'b1);
    adj = 1'b1; sel = 1'b1;
    run("bs_st_vis", 2, 4'b1101, S5, 1'b1);
    run("bs_mu_vis", 4, 4'b1011, S2, 1'b0);
    run("bs_mt_vis", 4, 4'b0111, S1, 1'b1);
    run_blank("bs_su_blank", 4);
    run_blank("bs_st_blank", 2);
    run("bs_st_vis2", 2, 4'b1101, S5, 1'b1);
    run("bs_mu_vis2", 4, 4'b1011, S2, 1'b0);
    run("bs_mt_ph1", 4, 4'b0111, S1, 1'b1);
    run_blank("bs_su_blank2", 4);
    run_blank("bs_st_blank2", 2);
    adj = 1'b0;
    run("bs_adj_off", 2, 4'b1101, S5, 1'b1);
    run("idle_mu", 4, 4'b1011, S2, 1'b0);
    run("idle_mt", 4, 4'b0111, S1, 1'b1);
    run("idle_su", 2, 4'b1110, S9, 1'b1);

    // Minutes blink, then SEL moves to seconds in the middle of the blank half-period.
    adj = 1'b1; sel = 1'b0;
    run("bm_su_vis", 2, 4'b1110, S9, 1'b1);
    run("bm_st_vis", 4, 4'b1101, S5, 1'b1);
    run("bm_mu_vis", 2, 4'b1011, S2, 1'b0);
    run_blank("bm_mu_blank", 2);
    run_blank("bm_mt_blank", 2);
    sel = 1'b1;
    run("bm_sel_mt_back", 2, 4'b0111, S1, 1'b1);
    run_blank("bm_sel_su_blank", 2);
    run("bm_su_ph0", 2, 4'b1110, S9, 1'b1);

    // Boundary values load only at the next frame.
    adj = 1'b0; sel = 1'b0; minutes = 6'd0; seconds = 6'd63;
    run("bd_st_old", 4, 4'b1101, S5, 1'b1);
    run("bd_mu_old", 4, 4'b1011, S2, 1'b0);
    run("bd_mt_old", 4, 4'b0111, S1, 1'b1);
    run("bd_su_3", 4, 4'b1110, S3, 1'b1);
    run("bd_st_6", 4, 4'b1101, S6, 1'b1);
    run("bd_mu_0", 4, 4'b1011, S0, 1'b0);
    run("bd_mt_0", 4, 4'b0111, S0, 1'b1);

    // Asynchronous reset while the minutes-units digit is lit.
    run("ar_su", 4, 4'b1110, S3, 1'b1);
    run("ar_st", 4, 4'b1101, S6, 1'b1);
    run("ar_mu", 2, 4'b1011, S0, 1'b0);
    #2 rst = 1'b1;
    #1 check("async_reset", 4'b1111, SB, 1'b1, 1'b1);
    minutes = 6'd7; seconds = 6'd45;
    @(negedge clk);
    check("reset_held", 4'b1111, SB, 1'b1, 1'b1);
    rst = 1'b0;
    run("rr_su", 4, 4'b1110, S5, 1'b1);
    run("rr_st", 4, 4'b1101, S4, 1'b1);
    run("rr_mu", 4, 4'b1011, S7, 1'b0);
    run("rr_mt", 4, 4'b0111, S0, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/seven_seg_display.md
Name: seven_seg_display

Overview:
- Downstream of minsec_counter in the Lab3 stopwatch; consumes its MINUTES/SECONDS plus the ADJ/SEL switch levels.
- Drives a 4-digit common-anode 7-segment display as MM.SS with time-multiplexed anodes.
- Blinks the field being adjusted while ADJ=1.
- Snapshots the inputs once per frame so a single refresh never mixes old and new values.

Parameters:
- BASE_CLK, 100_000_000, i_clk frequency in Hz.
- REFRESH_HZ, 500, digit-advance rate. Tick every BASE_CLK/REFRESH_HZ cycles.
- BLINK_HZ, 2, blink rate. Phase toggles every BASE_CLK/(2*BLINK_HZ) cycles.

Ports:
- i_clk  in  1  system clock
- i_rst  in  1  reset, asynchronous, active-high
- MINUTES  in  6  minutes value, 0..63 accepted
- SECONDS  in  6  seconds value, 0..63 accepted
- ADJ  in  1  adjust mode; enables blinking
- SEL  in  1  field select: 0 = minutes blink, 1 = seconds blink
- SEG  out  7  segments, active-low; SEG[0]=a ... SEG[6]=g
- DP  out  1  decimal point, active-low
- AN  out  4  anodes, active-low; AN[3]=min tens, AN[2]=min units, AN[1]=sec tens, AN[0]=sec units

Behaviour:
- Reset (async, any time, including mid-frame):
  - AN=4'b1111, SEG=7'b1111111, DP=1.
  - Digit index=0, refresh counter=0, blink counter=0, blink phase=0 (visible).
  - Snapshot=0; load_pending=1.
- Refresh counter:
  - Counts 0..BASE_CLK/REFRESH_HZ-1 and wraps.
  - Its terminal count is the tick; the tick advances the index 0→1→2→3→0.
- Snapshot:
  - Loads MINUTES/SECONDS on the first clock with load_pending=1 (load_pending then clears).
  - Also loads on every tick taking the index 3→0.
  - Input changes at any other time are not displayed until the next frame.
- Digit value, from the snapshot: tens=v/10, units=v%10.
  - 60..63 display as "60".."63".
  - Leading zeros are shown.
- Segment encoding, active-low gfedcba:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
- Outputs are registered, one cycle behind the index/snapshot.
  - First active-digit output appears on the first edge after reset release, with AN=1110.
  - At most one AN bit is low.
- DP=0 only when index=2 and that digit is not blanked; otherwise DP=1.
- Blink:
  - Blink counter and phase run continuously.
  - On an ADJ 0→1 edge, detected with a registered ADJ: blink counter=0 and phase=0, so the first blank comes a half-period later.
  - While ADJ=1 and phase=1, the selected field's two anodes are forced high and DP is forced 1 if index=2 is selected.
  - ADJ=0 means no blanking.
  - A SEL change takes effect on the next output register update; blink timing is unchanged.
- Simultaneous tick and ADJ edge: both actions apply in the same cycle.

Decomposition:
- Package seven_seg_pkg holds:
  - the ten digit encodings;
  - the blank pattern 7'b1111111;
  - digit-index localparams DIG_SU=0, DIG_ST=1, DIG_MU=2, DIG_MT=3.
- One combinational sub-module, seg_decoder: 4-bit digit in, 7-bit active-low segments out. Values 10..15 decode to blank.
- Counters, snapshot, blink logic and the output register live in the top.

Test Plan (BASE_CLK=16, REFRESH_HZ=4 → tick every 4 cycles; BLINK_HZ=1 → phase toggles every 8 cycles):
- Reset/scan: hold i_rst → AN=1111, SEG=1111111, DP=1. Release with MINUTES=12, SECONDS=34:
  - AN=1110, SEG=0011001 (4) for 4 cycles;
  - then AN=1101, SEG=0110000 (3);
  - then AN=1011, SEG=0100100 (2), DP=0;
  - then AN=0111, SEG=1111001 (1);
  - then back to AN=1110.
- Snapshot coherency: SECONDS 34→59 while AN=1101 → remaining digits of the frame still show "12.34". Next frame starts AN=1110, SEG=0010000 (9), then 0010010 (5).
- Blink seconds: ADJ=1, SEL=1 at an edge:
  - AN[1:0] active for 8 cycles, then forced 11 for 8 cycles, repeating;
  - AN[3:2] scan unaffected, DP on digit 2 still 0.
  - ADJ=0 → blanking stops at the next output update.
- Blink minutes plus SEL switch: ADJ=1, SEL=0 → AN[3:2] and DP blank in phase 1. SEL→1 mid-phase-1 → within 1 cycle the minutes reappear and the seconds blank.
- Boundary values: MINUTES=0, SECONDS=63 → digits 1000000, 1000000, 0000010, 0110000 ("00.63").
- Async reset mid-frame: assert i_rst while AN=1011 → outputs go to reset values without a clock edge. After release, scan restarts at AN=1110 with a fresh snapshot.
